addr_mode_sequencer: RTL

Parametrised 6502 addressing-mode sequencer. It sits between the decode stage and the ALU/writeback logic in the NES CPU pipeline. For each valid decoded instruction it resolves the effective address (EA) across all 13 addressing modes using a multi-cycle memory-read FSM. It fetches the load operand, applies page-cross and zero-page-wrap rules, and stalls upstream while busy.

---
 rtl/addr_mode_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/addr_mode_sequencer.sv
// 6502 addressing-mode sequencer: resolves the effective address of each decoded
// instruction, walks the pointer/operand reads over a req/ack port and stalls upstream while busy.
module addr_mode_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter bit PAGE_PENALTY = 1'b1,
  parameter bit JMP_IND_BUG  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic              is_store,
  input  logic [DATA_W-1:0] op_lo,
  input  logic [DATA_W-1:0] op_hi,
  input  logic [DATA_W-1:0] x_reg,
  input  logic [DATA_W-1:0] y_reg,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [DATA_W-1:0] operand,
  output logic              page_cross
);
  localparam int HI_W = ADDR_W - DATA_W;

  localparam logic [3:0] M_IMM  = 4'd2;
  localparam logic [3:0] M_ABS  = 4'd3;
  localparam logic [3:0] M_ZP   = 4'd4;
  localparam logic [3:0] M_ZPX  = 4'd5;
  localparam logic [3:0] M_ABSX = 4'd6;
  localparam logic [3:0] M_REL  = 4'd8;
  localparam logic [3:0] M_INDX = 4'd9;
  localparam logic [3:0] M_INDY = 4'd10;
  localparam logic [3:0] M_IND  = 4'd11;
  localparam logic [3:0] M_ZPY  = 4'd12;
  localparam logic [3:0] M_ABSY = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_PTR_LO, S_PTR_HI, S_FIX, S_DATA, S_DONE} state_e;

  state_e            state, state_d;
  logic [3:0]        mode_r;
  logic              store_r;
  logic [DATA_W-1:0] y_r;
  logic [DATA_W-1:0] lo_r, lo_d;
  logic [DATA_W-1:0] data_r, data_d;
  logic [ADDR_W-1:0] ptr_r, ptr_d;
  logic [ADDR_W-1:0] addr_r, addr_d;
  logic              cross_r, cross_d;

  logic [DATA_W-1:0] zp_x, zp_y, ptr_lo_inc;
  logic [ADDR_W-1:0] abs_base, abs_x, abs_y, rel_ea, ptr_base, ind_y_ea, ptr_hi_addr;

  function automatic logic [ADDR_W-1:0] zp(input logic [DATA_W-1:0] b);
    return {{HI_W{1'b0}}, b};
  endfunction

  // Indexed modes pay the FIX cycle on a page cross, and stores always pay it.
  function automatic state_e after_index(input logic crossed, input logic store);
    if (PAGE_PENALTY && (crossed || store)) return S_FIX;
    else if (store)                          return S_DONE;
    else                                     return S_DATA;
  endfunction

  assign zp_x       = op_lo + x_reg;
  assign zp_y       = op_lo + y_reg;
  assign abs_base   = {op_hi, op_lo};
  assign abs_x      = abs_base + {{HI_W{1'b0}}, x_reg};
  assign abs_y      = abs_base + {{HI_W{1'b0}}, y_reg};
  assign rel_ea     = pc_next + {{HI_W{op_lo[DATA_W-1]}}, op_lo};
  assign ptr_base   = {mem_rdata, lo_r};
  assign ind_y_ea   = ptr_base + {{HI_W{1'b0}}, y_r};
  assign ptr_lo_inc = ptr_r[DATA_W-1:0] + DATA_W'(1);
  // Zero-page pointers and the buggy IND fetch both wrap inside the pointer's page.
  assign ptr_hi_addr = (mode_r == M_IND && !JMP_IND_BUG) ? ptr_r + ADDR_W'(1)
                                                          : {ptr_r[ADDR_W-1:DATA_W], ptr_lo_inc};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state;
    lo_d     = lo_r;
    ptr_d    = ptr_r;
    addr_d   = addr_r;
    cross_d  = cross_r;
    data_d   = data_r;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state)
      S_IDLE: if (start) begin
        addr_d  = '0;
        cross_d = 1'b0;
        ptr_d   = '0;
        data_d  = (mode == M_IMM) ? op_lo : '0;
        state_d = S_DONE;  // ACC, IMP, IMM and unassigned codes carry no address
        case (mode)
          M_ABS:  begin addr_d = abs_base;  state_d = is_store ? S_DONE : S_DATA; end
          M_ZP:   begin addr_d = zp(op_lo); state_d = is_store ? S_DONE : S_DATA; end
          M_ZPX:  begin addr_d = zp(zp_x);  state_d = is_store ? S_DONE : S_DATA; end
          M_ZPY:  begin addr_d = zp(zp_y);  state_d = is_store ? S_DONE : S_DATA; end
          M_ABSX: begin
            addr_d  = abs_x;
            cross_d = abs_x[ADDR_W-1:DATA_W] != op_hi;
            state_d = after_index(cross_d, is_store);
          end
          M_ABSY: begin
            addr_d  = abs_y;
            cross_d = abs_y[ADDR_W-1:DATA_W] != op_hi;
            state_d = after_index(cross_d, is_store);
          end
          M_REL: begin
            addr_d  = rel_ea;
            cross_d = rel_ea[ADDR_W-1:DATA_W] != pc_next[ADDR_W-1:DATA_W];
          end
          M_INDX: begin ptr_d = zp(zp_x);  state_d = S_PTR_LO; end
          M_INDY: begin ptr_d = zp(op_lo); state_d = S_PTR_LO; end
          M_IND:  begin ptr_d = abs_base;  state_d = S_PTR_LO; end
          default: ;
        endcase
      end
      S_PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = ptr_r;
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = ptr_hi_addr;
        if (mem_ack) begin
          addr_d = ptr_base;
          case (mode_r)
            M_INDY: begin
              addr_d  = ind_y_ea;
              cross_d = ind_y_ea[ADDR_W-1:DATA_W] != mem_rdata;
              state_d = after_index(cross_d, store_r);
            end
            M_IND:   state_d = S_DONE;
            default: state_d = store_r ? S_DONE : S_DATA;
          endcase
        end
      end
      S_FIX:  state_d = store_r ? S_DONE : S_DATA;
      S_DATA: begin
        mem_req  = 1'b1;
        mem_addr = addr_r;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    // NOTE: this block only holds registers, so every assignment is non-blocking.
    if (rst) begin
      state      <= S_IDLE;
      mode_r     <= '0;
      store_r    <= 1'b0;
      y_r        <= '0;
      lo_r       <= '0;
      ptr_r      <= '0;
      addr_r     <= '0;
      cross_r    <= 1'b0;
      data_r     <= '0;
      ea         <= '0;
      operand    <= '0;
      page_cross <= 1'b0;
    end else begin
      state   <= state_d;
      lo_r    <= lo_d;
      ptr_r   <= ptr_d;
      addr_r  <= addr_d;
      cross_r <= cross_d;
      data_r  <= data_d;
      if (state == S_IDLE && start) begin
        mode_r  <= mode;
        store_r <= is_store;
        y_r     <= y_reg;
      end
      // Results are published only on entry to DONE and held until the next one.
      if (state_d == S_DONE && state != S_DONE) begin
        ea         <= addr_d;
        operand    <= data_d;
        page_cross <= cross_d;
      end
    end
  end
endmodule
